// File: rtl/l2cache_assoc.sv
// N-way set-associative write-back/write-allocate L2 line cache.
// Lines move to and from main memory in 64-bit beats through a simple done handshake.
module l2cache_assoc #(
  parameter int NFU            = 2,
  parameter int NWAYS          = 2,
  parameter int NSETS          = 1024,
  parameter int ADDRESS_LENGTH = 56
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDRESS_LENGTH-1:0] address,
  input  logic                      doFetch,
  input  logic                      doWrite,
  input  logic [NFU*32-1:0]         writeData,
  output logic                      doneFetch,
  output logic [NFU*32-1:0]         data,
  output logic                      doMainFetch,
  output logic                      doMainWrite,
  output logic [ADDRESS_LENGTH-1:0] mainAddress,
  output logic [63:0]               mainDataWrite,
  input  logic [63:0]               mainData,
  input  logic                      mainDone
);
  localparam int LINEW  = NFU * 32;
  localparam int NBEATS = LINEW / 64;
  localparam int OFFS   = $clog2(NFU * 4);
  localparam int IDX    = $clog2(NSETS);
  localparam int TAG    = ADDRESS_LENGTH - IDX - OFFS;
  localparam int WAYW   = (NWAYS > 1) ? $clog2(NWAYS) : 1;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, RESPOND} state_t;

  state_t              state_reg, state_next;
  logic                done_reg, done_next;
  logic                use_rd_reg, use_rd_next;
  logic [WAYW-1:0]     way_reg, way_next;
  logic [TAG-1:0]      vtag_reg, vtag_next;
  logic [BW-1:0]       beat_reg, beat_next;
  logic                is_write_reg, is_write_next;
  logic [LINEW-1:0]    line_reg, line_next;
  logic [NSETS-1:0]    valid_reg [NWAYS];
  logic [NSETS-1:0]    dirty_reg [NWAYS];
  logic [WAYW-1:0]     rr_reg [NSETS];

  logic [IDX-1:0]      idx;
  logic [TAG-1:0]      req_tag;
  logic                req;
  logic [NWAYS-1:0]    hit;
  logic [TAG-1:0]      tag_rd [NWAYS];
  logic [LINEW-1:0]    rd_line [NWAYS];
  logic                any_hit, any_inv, victim_dirty, last_beat;
  logic [WAYW-1:0]     hit_way, inv_way, victim, rr_next;
  logic                inst_en, inst_dirty, rr_inc;
  logic [WAYW-1:0]     inst_way;
  logic [LINEW-1:0]    inst_line, fill_line;
  logic [ADDRESS_LENGTH-1:0] line_base, victim_base, beat_off;

  assign idx       = address[OFFS +: IDX];
  assign req_tag   = address[IDX+OFFS +: TAG];
  assign req       = doFetch | doWrite;
  assign last_beat = (beat_reg == BW'(NBEATS - 1));
  assign rr_next   = (rr_reg[idx] == WAYW'(NWAYS - 1)) ? '0 : rr_reg[idx] + 1'b1;

  // Tags read asynchronously for same-cycle hit detection; line data uses a registered read.
  for (genvar gi = 0; gi < NWAYS; gi++) begin : g_way
    logic [LINEW-1:0] mem  [NSETS];
    logic [TAG-1:0]   tags [NSETS];
    logic [LINEW-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (inst_en && inst_way == WAYW'(gi)) begin
        mem[idx]  <= inst_line;
        tags[idx] <= req_tag;
      end
      rd_q <= mem[idx];
    end

    assign rd_line[gi] = rd_q;
    assign tag_rd[gi]  = tags[idx];
    assign hit[gi]     = valid_reg[gi][idx] && (tags[idx] == req_tag);
  end

  always_comb begin
    any_hit = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (hit[w]) begin
        any_hit = 1'b1;
        hit_way = WAYW'(w);
      end
      if (!valid_reg[w][idx]) begin
        any_inv = 1'b1;
        inv_way = WAYW'(w);
      end
    end
  end

  assign victim       = any_inv ? inv_way : rr_reg[idx];
  assign victim_dirty = valid_reg[victim][idx] && dirty_reg[victim][idx];

  always_comb begin
    state_next    = state_reg;
    done_next     = 1'b0;
    use_rd_next   = use_rd_reg;
    way_next      = way_reg;
    vtag_next     = vtag_reg;
    beat_next     = beat_reg;
    is_write_next = is_write_reg;
    line_next     = line_reg;
    inst_en       = 1'b0;
    inst_way      = way_reg;
    inst_line     = writeData;
    inst_dirty    = 1'b1;
    rr_inc        = 1'b0;
    fill_line     = line_reg;
    fill_line[int'(beat_reg)*64 +: 64] = mainData;

    case (state_reg)
      IDLE: begin
        // The request is still held during its own done cycle and must not be looked up again.
        if (req && !done_reg) begin
          is_write_next = doWrite;
          beat_next     = '0;
          if (any_hit) begin
            done_next = 1'b1;
            way_next  = hit_way;
            if (doWrite) begin
              inst_en     = 1'b1;
              inst_way    = hit_way;
              line_next   = writeData;
              use_rd_next = 1'b0;
            end else begin
              use_rd_next = 1'b1;
            end
          end else begin
            way_next  = victim;
            vtag_next = tag_rd[victim];
            rr_inc    = !any_inv;
            if (victim_dirty) begin
              state_next = WRITEBACK;
            end else if (doWrite) begin
              inst_en     = 1'b1;
              inst_way    = victim;
              line_next   = writeData;
              done_next   = 1'b1;
              use_rd_next = 1'b0;
            end else begin
              state_next = FILL;
            end
          end
        end
      end
      WRITEBACK: begin
        if (mainDone) begin
          if (last_beat) begin
            beat_next = '0;
            if (is_write_reg) begin
              inst_en     = 1'b1;
              line_next   = writeData;
              done_next   = 1'b1;
              use_rd_next = 1'b0;
              state_next  = RESPOND;
            end else begin
              state_next = FILL;
            end
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end
      FILL: begin
        if (mainDone) begin
          line_next = fill_line;
          if (last_beat) begin
            inst_en     = 1'b1;
            inst_line   = fill_line;
            inst_dirty  = 1'b0;
            done_next   = 1'b1;
            use_rd_next = 1'b0;
            state_next  = RESPOND;
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end
      RESPOND: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      done_reg     <= 1'b0;
      use_rd_reg   <= 1'b0;
      way_reg      <= '0;
      vtag_reg     <= '0;
      beat_reg     <= '0;
      is_write_reg <= 1'b0;
      line_reg     <= '0;
      for (int w = 0; w < NWAYS; w++) begin
        valid_reg[w] <= '0;
        dirty_reg[w] <= '0;
      end
      for (int s = 0; s < NSETS; s++) rr_reg[s] <= '0;
    end else begin
      state_reg    <= state_next;
      done_reg     <= done_next;
      use_rd_reg   <= use_rd_next;
      way_reg      <= way_next;
      vtag_reg     <= vtag_next;
      beat_reg     <= beat_next;
      is_write_reg <= is_write_next;
      line_reg     <= line_next;
      if (inst_en) begin
        valid_reg[inst_way][idx] <= 1'b1;
        dirty_reg[inst_way][idx] <= inst_dirty;
      end
      if (rr_inc) rr_reg[idx] <= rr_next;
    end
  end

  assign line_base   = address & ~ADDRESS_LENGTH'(NFU * 4 - 1);
  assign victim_base = {vtag_reg, idx, {OFFS{1'b0}}};
  assign beat_off    = ADDRESS_LENGTH'({beat_reg, 3'b000});

  assign doneFetch     = done_reg;
  assign data          = done_reg ? (use_rd_reg ? rd_line[way_reg] : line_reg) : '0;
  assign doMainWrite   = (state_reg == WRITEBACK);
  assign doMainFetch   = (state_reg == FILL);
  assign mainAddress   = (state_reg == WRITEBACK) ? victim_base + beat_off :
                         (state_reg == FILL)      ? line_base + beat_off : '0;
  assign mainDataWrite = (state_reg == WRITEBACK) ? rd_line[way_reg][int'(beat_reg)*64 +: 64] : '0;
endmodule

// File: tb/tb_l2cache_assoc.sv
// Bench for l2cache_assoc: directed scenarios plus random traffic against a line-level cache model
// and a main-memory responder with random beat latency.
module tb_l2cache_assoc;
  localparam int NFU = 4, NWAYS = 2, NSETS = 1024, AL = 56;
  localparam int LINEW = NFU * 32, NBEATS = LINEW / 64, OFFS = $clog2(NFU * 4);
  localparam int IDX = $clog2(NSETS), TAG = AL - IDX - OFFS;

  logic             clk = 1'b0, rst = 1'b1;
  logic [AL-1:0]    address = '0;
  logic             doFetch = 1'b0, doWrite = 1'b0;
  logic [LINEW-1:0] writeData = '0;
  logic             doneFetch, doMainFetch, doMainWrite;
  logic [LINEW-1:0] data;
  logic [AL-1:0]    mainAddress;
  logic [63:0]      mainDataWrite;
  logic [63:0]      mainData = '0;
  logic             mainDone = 1'b0;

  l2cache_assoc #(.NFU(NFU), .NWAYS(NWAYS), .NSETS(NSETS), .ADDRESS_LENGTH(AL)) dut (
    .clk(clk), .rst(rst), .address(address), .doFetch(doFetch), .doWrite(doWrite),
    .writeData(writeData), .doneFetch(doneFetch), .data(data), .doMainFetch(doMainFetch),
    .doMainWrite(doMainWrite), .mainAddress(mainAddress), .mainDataWrite(mainDataWrite),
    .mainData(mainData), .mainDone(mainDone));

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [AL-1:0] a; logic [63:0] d; } beat_t;

  int vectors = 0, miscompares = 0, ntxn = 0;
  bit               m_valid [NWAYS][NSETS];
  bit               m_dirty [NWAYS][NSETS];
  logic [TAG-1:0]   m_tag   [NWAYS][NSETS];
  logic [LINEW-1:0] m_data  [NWAYS][NSETS];
  int               m_rr    [NSETS];
  logic [63:0]      mm [logic [AL-1:0]];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] memrd(input logic [AL-1:0] a);
    if (mm.exists(a)) return mm[a];
    return {a[31:0] ^ 32'h5A5A_1234, a[31:0] + 32'h0BAD_F00D};
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NWAYS; w++)
      for (int s = 0; s < NSETS; s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
    for (int s = 0; s < NSETS; s++) m_rr[s] = 0;
  endtask

  // Called at a negedge; returns at the negedge after the done cycle with the request dropped.
  task automatic txn(input bit wr, input bit both, input logic [AL-1:0] a, input logic [LINEW-1:0] wd);
    int s, hitw, vic, cyc, cnt, lat;
    bit got, overlap;
    logic [TAG-1:0]   t;
    logic [AL-1:0]    base, va;
    logic [LINEW-1:0] exp_line, obs_line;
    beat_t exp_q[$], obs_q[$];
    s = int'(a[OFFS +: IDX]);
    t = a[IDX+OFFS +: TAG];
    base = a & ~AL'(NFU * 4 - 1);
    hitw = -1;
    for (int w = 0; w < NWAYS; w++) if (m_valid[w][s] && m_tag[w][s] == t) hitw = w;
    if (hitw >= 0) begin
      if (wr) begin
        m_data[hitw][s] = wd;
        m_dirty[hitw][s] = 1'b1;
      end
      exp_line = m_data[hitw][s];
    end else begin
      vic = -1;
      for (int w = NWAYS - 1; w >= 0; w--) if (!m_valid[w][s]) vic = w;
      if (vic < 0) begin
        vic = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % NWAYS;
      end
      if (m_valid[vic][s] && m_dirty[vic][s]) begin
        va = {m_tag[vic][s], IDX'(s), {OFFS{1'b0}}};
        for (int b = 0; b < NBEATS; b++) begin
          exp_q.push_back('{1'b1, va + AL'(b * 8), m_data[vic][s][b*64 +: 64]});
          mm[va + AL'(b * 8)] = m_data[vic][s][b*64 +: 64];
        end
      end
      if (wr) exp_line = wd;
      else for (int b = 0; b < NBEATS; b++) begin
        exp_line[b*64 +: 64] = memrd(base + AL'(b * 8));
        exp_q.push_back('{1'b0, base + AL'(b * 8), 64'h0});
      end
      m_valid[vic][s] = 1'b1;
      m_dirty[vic][s] = wr;
      m_tag[vic][s]   = t;
      m_data[vic][s]  = exp_line;
    end

    address = a; writeData = wd; doWrite = wr; doFetch = wr ? both : 1'b1;
    got = 1'b0; overlap = 1'b0; cnt = 0; lat = $urandom_range(0, 3); obs_line = '0; cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      cyc = i;
      if (doMainFetch && doMainWrite) overlap = 1'b1;
      if (doneFetch) begin
        got = 1'b1;
        obs_line = data;
        break;
      end
      if (mainDone) begin
        mainDone = 1'b0;
        cnt = 0;
      end else if (doMainFetch || doMainWrite) begin
        if (cnt == lat) begin
          obs_q.push_back('{doMainWrite, mainAddress, doMainWrite ? mainDataWrite : 64'h0});
          mainData = doMainFetch ? memrd(mainAddress) : 64'(~mainAddress);
          mainDone = 1'b1;
          lat = $urandom_range(0, 3);
        end else cnt++;
      end else if ($urandom_range(0, 3) == 0) begin
        mainData = {$urandom(), $urandom()};
        mainDone = 1'b1;
      end
    end
    mainDone = 1'b0;
    @(negedge clk);
    check("done_single_pulse", 128'(doneFetch), 128'(0));
    doFetch = 1'b0; doWrite = 1'b0;

    ntxn++;
    $display("txn %0d %s a=%h beats=%0d/%0d cycles=%0d data=%h", ntxn, wr ? "WR" : "RD", a,
             obs_q.size(), exp_q.size(), cyc, obs_line);
    check("done_seen", 128'(got), 128'(1));
    check("line_data", obs_line, exp_line);
    check("beat_count", 128'(obs_q.size()), 128'(exp_q.size()));
    check("no_overlap", 128'(overlap), 128'(0));
    if (exp_q.size() == 0) check("hit_latency", 128'(cyc), 128'(1));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check("beat_kind", 128'(obs_q[i].wr), 128'(exp_q[i].wr));
      check("beat_addr", 128'(obs_q[i].a), 128'(exp_q[i].a));
      check("beat_wdata", 128'(obs_q[i].d), 128'(exp_q[i].d));
    end
  endtask

  initial begin
    bit found, pulse;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_done", 128'(doneFetch), 128'(0));
    check("rst_mainfetch", 128'(doMainFetch), 128'(0));
    check("rst_mainwrite", 128'(doMainWrite), 128'(0));
    check("rst_data", data, 128'(0));
    check("rst_mainaddr", 128'(mainAddress), 128'(0));
    check("rst_mainwdata", 128'(mainDataWrite), 128'(0));

    txn(1'b0, 1'b0, 56'h1000, '0);
    txn(1'b0, 1'b0, 56'h1000, '0);
    txn(1'b0, 1'b0, 56'h0, '0);
    txn(1'b0, 1'b0, 56'h10000, '0);
    txn(1'b0, 1'b0, 56'h20000, '0);
    txn(1'b0, 1'b0, 56'h10000, '0);
    txn(1'b1, 1'b0, 56'h2000, {16{8'hAA}});
    txn(1'b0, 1'b0, 56'h2000, '0);
    txn(1'b1, 1'b1, 56'h30000, {4{32'hDEAD_BEEF}});
    txn(1'b1, 1'b0, 56'h40000, {4{32'h1234_5678}});
    txn(1'b0, 1'b0, 56'h50000, '0);
    txn(1'b0, 1'b0, 56'h30000, '0);

    // Reset in the second FILL cycle aborts the request.
    address = 56'h7000; doFetch = 1'b1; doWrite = 1'b0; mainDone = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (doMainFetch) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_fill_seen", 128'(found), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_fetch_low", 128'(doMainFetch), 128'(0));
    check("abort_no_done", 128'(doneFetch), 128'(0));
    rst = 1'b0; doFetch = 1'b0;
    model_reset();
    pulse = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (doneFetch) pulse = 1'b1;
    end
    check("abort_no_pulse", 128'(pulse), 128'(0));
    txn(1'b0, 1'b0, 56'h1000, '0);
    txn(1'b0, 1'b0, 56'h2000, '0);

    for (int n = 0; n < 80; n++) begin
      logic [AL-1:0] a;
      a = (AL'($urandom_range(0, 4)) << (IDX + OFFS)) | (AL'($urandom_range(0, 3)) << OFFS)
          | AL'($urandom_range(0, NFU * 4 - 1));
      txn($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), a,
          {$urandom(), $urandom(), $urandom(), $urandom()});
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
